rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (write_enb/di/sel/addr_wr) between two sources:

---
 rtl/rf_wb_arbiter_if.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle for rf_wb_arbiter.
// Carries the writeback request (wb_*), the load-return handshake (ld_*),
// the shared register-file write port (rf_*), and the status outputs
// (pipe_stall, pend_mask, fifo_count).
//   master : the surrounding pipeline / load path (drives wb_*, ld_valid/addr/sel/data)
//   slave  : the arbiter (drives ld_ready, rf_*, pipe_stall, pend_mask, fifo_count)
// Bit vectors use ascending [0:N] ranges so that pend_mask[i] is register i.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                    wb_en;
    logic [0:4]              wb_addr;
    logic [0:2]              wb_sel;
    logic [0:63]             wb_data;

    logic                    ld_valid;
    logic                    ld_ready;
    logic [0:4]              ld_addr;
    logic [0:2]              ld_sel;
    logic [0:63]             ld_data;

    logic                    rf_write_enb;
    logic [0:4]              rf_addr_wr;
    logic [0:2]              rf_sel;
    logic [0:63]             rf_di;

    logic                    pipe_stall;
    logic [0:31]             pend_mask;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output wb_en, wb_addr, wb_sel, wb_data,
        output ld_valid, ld_addr, ld_sel, ld_data,
        input  ld_ready,
        input  rf_write_enb, rf_addr_wr, rf_sel, rf_di,
        input  pipe_stall, pend_mask, fifo_count
    );

    modport slave (
        input  wb_en, wb_addr, wb_sel, wb_data,
        input  ld_valid, ld_addr, ld_sel, ld_data,
        output ld_ready,
        output rf_write_enb, rf_addr_wr, rf_sel, rf_di,
        output pipe_stall, pend_mask, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single register-file write port between pipeline writeback
// (fixed priority, no backpressure) and load/NoC return data (valid/ready).
// Load writes that lose to WB are queued in a DEPTH-entry FIFO which drains
// on idle WB cycles. If the FIFO head is blocked by WB for STARVE_MAX
// consecutive cycles, pipe_stall is raised for exactly one cycle and the head
// is written instead of WB.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : rf_wb_arbiter_if.slave (wb_*, ld_*, rf_*, pipe_stall,
//                pend_mask, fifo_count)
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic             clk,
    input logic             reset,
    rf_wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {ST_NORMAL, ST_DRAIN} state_t;

    // FIFO storage; the head is read combinationally because it must be
    // presented to the register file in the same cycle it is granted.
    logic [0:4]     mem_addr_reg [DEPTH];
    logic [0:2]     mem_sel_reg  [DEPTH];
    logic [0:63]    mem_data_reg [DEPTH];
    logic           slot_valid_reg  [DEPTH];
    logic           slot_valid_next [DEPTH];
    logic [0:4]     slot_addr_next  [DEPTH];

    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [SW-1:0]  starve_reg, starve_next;
    state_t         state_reg, state_next;
    logic           pipe_stall_reg;
    logic [0:31]    pend_mask_reg, pend_mask_next;

    logic fifo_empty, fifo_full, ld_live;
    logic grant_wb, do_pop, do_bypass, do_push;
    logic           wr_enb;
    logic [0:4]     wr_addr;
    logic [0:2]     wr_sel;
    logic [0:63]    wr_data;

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == CW'(DEPTH));
    assign bus.ld_ready = ~fifo_full & ~reset;
    // Register 0 loads are accepted but never written or queued.
    assign ld_live      = bus.ld_valid & bus.ld_ready & (bus.ld_addr != 5'd0);

    always_comb begin
        grant_wb  = 1'b0;
        do_pop    = 1'b0;
        do_bypass = 1'b0;
        if (!reset) begin
            if (state_reg == ST_DRAIN) begin
                do_pop = ~fifo_empty;
            end else if (bus.wb_en) begin
                grant_wb = 1'b1;
            end else if (!fifo_empty) begin
                do_pop = 1'b1;
            end else begin
                do_bypass = ld_live;
            end
        end
    end

    assign do_push = ld_live & ~do_bypass;

    always_comb begin
        wr_enb  = 1'b0;
        wr_addr = '0;
        wr_sel  = '0;
        wr_data = '0;
        if (grant_wb) begin
            wr_enb  = 1'b1;
            wr_addr = bus.wb_addr;
            wr_sel  = bus.wb_sel;
            wr_data = bus.wb_data;
        end else if (do_pop) begin
            wr_enb  = 1'b1;
            wr_addr = mem_addr_reg[rd_ptr_reg];
            wr_sel  = mem_sel_reg[rd_ptr_reg];
            wr_data = mem_data_reg[rd_ptr_reg];
        end else if (do_bypass) begin
            wr_enb  = 1'b1;
            wr_addr = bus.ld_addr;
            wr_sel  = bus.ld_sel;
            wr_data = bus.ld_data;
        end
    end

    assign bus.rf_write_enb = wr_enb;
    assign bus.rf_addr_wr   = wr_addr;
    assign bus.rf_sel       = wr_sel;
    assign bus.rf_di        = wr_data;
    assign bus.pipe_stall   = pipe_stall_reg;
    assign bus.pend_mask    = pend_mask_reg;
    assign bus.fifo_count   = count_reg;

    // Post-update view of every slot, so pend_mask reflects the FIFO as it
    // will be after this edge.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            slot_valid_next[s] = slot_valid_reg[s];
            slot_addr_next[s]  = mem_addr_reg[s];
            if (do_pop && rd_ptr_reg == PW'(s)) begin
                slot_valid_next[s] = 1'b0;
            end
            if (do_push && wr_ptr_reg == PW'(s)) begin
                slot_valid_next[s] = 1'b1;
                slot_addr_next[s]  = bus.ld_addr;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            logic [DEPTH-1:0] hit;
            always_comb begin
                for (int s = 0; s < DEPTH; s++) begin
                    hit[s] = slot_valid_next[s] && (slot_addr_next[s] == 5'(gi));
                end
            end
            assign pend_mask_next[gi] = (gi != 0) && (|hit);
        end
    endgenerate

    // Starvation counts only cycles where an already-queued head lost to WB.
    always_comb begin
        starve_next = starve_reg;
        state_next  = ST_NORMAL;
        if (do_pop || state_reg == ST_DRAIN) begin
            starve_next = '0;
        end else if (grant_wb && !fifo_empty) begin
            starve_next = starve_reg + 1'b1;
        end
        if (state_reg == ST_NORMAL && starve_next == SW'(STARVE_MAX)) begin
            state_next = ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr_reg[wr_ptr_reg] <= bus.ld_addr;
            mem_sel_reg[wr_ptr_reg]  <= bus.ld_sel;
            mem_data_reg[wr_ptr_reg] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_reg     <= '0;
            state_reg      <= ST_NORMAL;
            pipe_stall_reg <= 1'b0;
            pend_mask_reg  <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                slot_valid_reg[s] <= 1'b0;
            end
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg      <= count_reg + CW'(do_push) - CW'(do_pop);
            starve_reg     <= starve_next;
            state_reg      <= state_next;
            pipe_stall_reg <= (state_next == ST_DRAIN);
            pend_mask_reg  <= pend_mask_next;
            for (int s = 0; s < DEPTH; s++) begin
                slot_valid_reg[s] <= slot_valid_next[s];
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a write-order scoreboard fed by a
// queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus();

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [0:4]  addr;
        logic [0:2]  sel;
        logic [0:63] data;
    } ent_t;

    typedef struct {
        logic       we;
        logic [0:4] wa;
        logic       lv;
        logic [0:4] la;
        logic       exp_enb;
        logic [0:4] exp_addr;
        int         exp_count;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];     // model FIFO contents
    ent_t sb[$];     // expected register-file writes, in order
    bit   m_drain;
    int   m_starve;
    ent_t mon_e;
    vec_t vecs [11];

    logic       seen_enb, seen_stall, seen_ready;
    logic [0:4] seen_addr;
    int         li, wi, stall_at;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [0:63] wbd(input int k);
        return 64'hB000_0000_0000_0000 | 64'(k);
    endfunction

    function automatic logic [0:31] model_mask();
        logic [0:31] m = '0;
        foreach (mq[k]) m[mq[k].addr] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive, predict, compare combinational outputs, advance
    // the model, then compare registered outputs after the edge.
    task automatic step(input logic we, input logic [0:4] wa, input logic [0:2] ws, input logic [0:63] wd,
                        input logic lv, input logic [0:4] la, input logic [0:2] ls, input logic [0:63] ld);
        bit ready, live, nonempty, popped, bypass, wbg, exp_wr;
        bus.wb_en = we;  bus.wb_addr = wa;  bus.wb_sel = ws;  bus.wb_data = wd;
        bus.ld_valid = lv; bus.ld_addr = la; bus.ld_sel = ls; bus.ld_data = ld;
        #1;
        nonempty = (mq.size() != 0);
        ready    = (mq.size() < DEPTH);
        live     = lv && ready && (la != 5'd0);
        popped = 0; bypass = 0; wbg = 0;
        if (m_drain) begin
            if (nonempty) begin sb.push_back(mq.pop_front()); popped = 1; end
        end else if (we) begin
            sb.push_back('{wa, ws, wd}); wbg = 1;
        end else if (nonempty) begin
            sb.push_back(mq.pop_front()); popped = 1;
        end else if (live) begin
            sb.push_back('{la, ls, ld}); bypass = 1;
        end
        if (live && !bypass) mq.push_back('{la, ls, ld});
        exp_wr = popped || bypass || wbg;
        check("ld_ready", 64'(bus.ld_ready), 64'(ready));
        check("write_enb", 64'(bus.rf_write_enb), 64'(exp_wr));
        seen_enb = bus.rf_write_enb; seen_addr = bus.rf_addr_wr;
        seen_stall = bus.pipe_stall; seen_ready = bus.ld_ready;
        if (popped || m_drain) m_starve = 0;
        else if (wbg && nonempty) m_starve++;
        m_drain = !m_drain && (m_starve == STARVE_MAX);
        @(posedge clk); #1;
        check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
        check("pend_mask", 64'(bus.pend_mask), 64'(model_mask()));
        check("pipe_stall", 64'(bus.pipe_stall), 64'(m_drain));
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 3'd0, 64'd0, 1'b0, 5'd0, 3'd0, 64'd0);
    endtask

    // Reset for two edges with requests active; nothing may be written or accepted.
    task automatic do_reset();
        reset = 1'b1;
        bus.wb_en = 1'b1;    bus.wb_addr = 5'd9;  bus.wb_sel = 3'd0; bus.wb_data = 64'h99;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd11; bus.ld_sel = 3'd0; bus.ld_data = 64'h11;
        #1;
        check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("rst_write_enb", 64'(bus.rf_write_enb), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.wb_en = 1'b0; bus.ld_valid = 1'b0;
        mq.delete(); m_drain = 0; m_starve = 0;
        check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rst_pend_mask", 64'(bus.pend_mask), 64'd0);
        check("rst_pipe_stall", 64'(bus.pipe_stall), 64'd0);
    endtask

    // Write monitor: every DUT write must match the next expected write.
    always @(negedge clk) begin
        checks++;
        if (bus.rf_write_enb === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.rf_addr_wr, bus.rf_di);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rf_addr_wr !== mon_e.addr || bus.rf_sel !== mon_e.sel || bus.rf_di !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d sel=%0d data=%h, required addr=%0d sel=%0d data=%h",
                             bus.rf_addr_wr, bus.rf_sel, bus.rf_di, mon_e.addr, mon_e.sel, mon_e.data);
                end else begin
                    $display("write addr=%0d sel=%0d data=%h", bus.rf_addr_wr, bus.rf_sel, bus.rf_di);
                end
            end
        end else if (bus.rf_write_enb !== 1'b0 || bus.rf_addr_wr !== '0 ||
                     bus.rf_sel !== '0 || bus.rf_di !== '0) begin
            errors++;
            $display("FAIL idle_port: got enb=%b addr=%0d sel=%0d data=%h, required all zero",
                     bus.rf_write_enb, bus.rf_addr_wr, bus.rf_sel, bus.rf_di);
        end
    end

    initial begin
        //            we    wa     lv    la     enb   addr   count
        vecs[0]  = '{1'b0, 5'd0, 1'b1, 5'd5,  1'b1, 5'd5,  0}; // bypass, data A5
        vecs[1]  = '{1'b1, 5'd3, 1'b1, 5'd7,  1'b1, 5'd3,  1}; // WB wins, LD queued
        vecs[2]  = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd7,  0}; // queued LD drains
        vecs[3]  = '{1'b0, 5'd0, 1'b1, 5'd0,  1'b0, 5'd0,  0}; // r0 load discarded
        vecs[4]  = '{1'b1, 5'd9, 1'b1, 5'd0,  1'b1, 5'd9,  0}; // r0 load under WB
        vecs[5]  = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  0};
        vecs[6]  = '{1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 5'd4,  1};
        vecs[7]  = '{1'b1, 5'd6, 1'b1, 5'd13, 1'b1, 5'd6,  2};
        vecs[8]  = '{1'b0, 5'd0, 1'b1, 5'd14, 1'b1, 5'd12, 2}; // pop + push
        vecs[9]  = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd13, 1};
        vecs[10] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd14, 0};

        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_sel = '0; bus.wb_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_sel = '0; bus.ld_data = '0;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].we, vecs[i].wa, 3'd0, wbd(int'(vecs[i].wa)),
                 vecs[i].lv, vecs[i].la, 3'd0, 64'hA0 | 64'(vecs[i].la));
            check($sformatf("vec%0d_enb", i), 64'(seen_enb), 64'(vecs[i].exp_enb));
            check($sformatf("vec%0d_addr", i), 64'(seen_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].exp_count));
            if (i == 1) check("vec1_pend7", 64'(bus.pend_mask[7]), 64'd1);
        end

        // Continuous WB with five loads: FIFO fills, fifth load waits.
        li = 0; wi = 1;
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 5'(wi), 3'(wi % 5), wbd(wi),
                 li < 5, 5'(16 + li), 3'd1, 64'hC000_0000_0000_0000 | 64'(li));
            if (c == 4) begin
                check("full_ld_ready", 64'(seen_ready), 64'd0);
                check("full_count", 64'(bus.fifo_count), 64'd4);
            end
            if (seen_ready && li < 5) li++;
            if (!seen_stall) wi++;
        end
        check("all_loads_taken", 64'(li), 64'd5);
        for (int k = 0; k < 10 && bus.fifo_count != 0; k++) idle_step();
        check("drained", 64'(bus.fifo_count), 64'd0);

        // One queued load under continuous WB: forced drain on the 9th cycle.
        wi = 10; stall_at = 0;
        step(1'b1, 5'(wi), 3'd0, wbd(wi), 1'b1, 5'd22, 3'd2, 64'hD22);
        wi++;
        for (int c = 1; c <= 11; c++) begin
            step(1'b1, 5'(wi), 3'd0, wbd(wi), 1'b0, 5'd0, 3'd0, 64'd0);
            if (seen_stall && stall_at == 0) stall_at = c;
            if (!seen_stall) wi++;
        end
        check("stall_cycle", 64'(stall_at), 64'd9);

        // Reset with three queued loads drops them.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 5'(23 + c), 3'd0, wbd(c), 1'b1, 5'(24 + c), 3'd4, 64'(c));
        end
        check("pre_reset_count", 64'(bus.fifo_count), 64'd3);
        do_reset();
        idle_step();
        idle_step();

        // Push and pop every cycle through several pointer wraps.
        step(1'b1, 5'd2, 3'd0, wbd(2), 1'b1, 5'd21, 3'd3, 64'h2121);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 5'd0, 3'd0, 64'd0, 1'b1, 5'(1 + (c * 7) % 31), 3'(c % 5), {$urandom, $urandom});
            check("stream_count", 64'(bus.fifo_count), 64'd1);
        end
        idle_step();
        check("stream_empty", 64'(bus.fifo_count), 64'd0);
        check("writes_outstanding", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
